// File: rtl/bw_mem_req_dispatch_pkg.sv
// Memory-request types shared by the request queue and the dispatcher:
// function codes, size codes and the size-to-byte-lane helper.
package rfBlackWidowPkg;

   localparam int MR_AWID = 32;

   localparam logic [3:0] MR_LOAD  = 4'h1;
   localparam logic [3:0] MR_LOADZ = 4'h2;
   localparam logic [3:0] MR_STORE = 4'h3;

   // Size codes carry their byte count so lane math stays trivial
   localparam logic [3:0] SZ_BYT   = 4'd1;
   localparam logic [3:0] SZ_WYDE  = 4'd2;
   localparam logic [3:0] SZ_TETRA = 4'd4;
   localparam logic [3:0] SZ_PENTA = 4'd5;
   localparam logic [3:0] SZ_OCTA  = 4'd8;
   localparam logic [3:0] SZ_DECI  = 4'd10;

   typedef struct packed {
      logic [3:0]         func;
      logic [3:0]         sz;
      logic [MR_AWID-1:0] adr;
      logic [127:0]       dat;
      logic [7:0]         tid;
   } MemoryRequest;

   function automatic logic [15:0] fnSel(input logic [3:0] sz);
      logic [15:0] sel;
      case (sz)
         SZ_BYT:   sel = 16'h0001;
         SZ_WYDE:  sel = 16'h0003;
         SZ_TETRA: sel = 16'h000F;
         SZ_PENTA: sel = 16'h001F;
         SZ_OCTA:  sel = 16'h00FF;
         SZ_DECI:  sel = 16'h03FF;
         default:  sel = 16'h0000;
      endcase
      return sel;
   endfunction

endpackage

// File: rtl/bw_mem_req_dispatch_load_align.sv
// Load-data reassembly: right-aligns the two captured beats, keeps sz bytes
// and sign- or zero-extends to 128 bits. Non-load functions yield zero.
module bw_load_align
   import rfBlackWidowPkg::*;
(
   input  logic [127:0] hi,
   input  logic [127:0] lo,
   input  logic [3:0]   adr_lo,
   input  logic [3:0]   sz,
   input  logic [3:0]   func,
   output logic [127:0] res
);

   logic [127:0] raw;
   logic [15:0]  sel;
   logic         fill;

   always_comb begin
      raw  = 128'({hi, lo} >> {adr_lo, 3'b000});
      sel  = fnSel(sz);
      fill = 1'b0;
      res  = '0;
      // The last selected lane is the most significant byte of the operand
      for (int i = 0; i < 16; i++) begin
         if (sel[i]) fill = raw[8*i+7] & (func == MR_LOAD);
      end
      for (int i = 0; i < 16; i++) begin
         res[8*i +: 8] = sel[i] ? raw[8*i +: 8] : {8{fill}};
      end
      if (func != MR_LOAD && func != MR_LOADZ) res = '0;
   end

endmodule

// File: rtl/bw_mem_req_dispatch.sv
// Pops one memory request at a time and runs it on the 128-bit bus as one
// beat, or as a locked pair of beats when the lanes cross a 16-byte line.
module bw_mem_req_dispatch
   import rfBlackWidowPkg::*;
#(
   parameter int AWID  = MR_AWID,
   parameter int TOLIM = 1023
)(
   input  logic            clk,
   input  logic            rst,
   input  logic            q_valid,
   input  MemoryRequest    q_req,
   output logic            q_rd,
   output logic            cyc_o,
   output logic            stb_o,
   output logic            we_o,
   output logic [15:0]     sel_o,
   output logic [AWID-1:0] adr_o,
   output logic [127:0]    dat_o,
   input  logic            ack_i,
   input  logic            err_i,
   input  logic [127:0]    dat_i,
   output logic            resp_v,
   input  logic            resp_rdy,
   output logic [7:0]      resp_tid,
   output logic [127:0]    resp_dat,
   output logic            resp_err,
   output logic            busy
);

   localparam int TW = $clog2(TOLIM + 1);

   typedef enum logic [1:0] {IDLE, B1, B2, RESP} state_t;

   state_t          state_q, state_d;
   logic [3:0]      func_q, sz_q;
   logic [AWID-1:0] adr_q;
   logic [7:0]      tid_q;
   logic [31:0]     sel32_q;
   logic [255:0]    sdat_q;
   logic [127:0]    lo_q, hi_q;
   logic            cyc_q, stb_q, err_q;
   logic [TW-1:0]   tmo_q;

   logic            func_ok, split, tmo_exp, beat_fail, beat_ok;
   logic [127:0]    ext;

   assign func_ok   = (q_req.func == MR_LOAD) | (q_req.func == MR_LOADZ) |
                      (q_req.func == MR_STORE);
   assign split     = |sel32_q[31:16];
   // A beat is only live while stb is up; ack/err in the inter-beat gap are ignored
   assign tmo_exp   = stb_q & ~ack_i & (tmo_q == TW'(TOLIM - 1));
   assign beat_fail = stb_q & (err_i | tmo_exp);
   assign beat_ok   = stb_q & ack_i & ~err_i;

   always_comb begin
      state_d = state_q;
      q_rd    = 1'b0;
      case (state_q)
         IDLE: begin
            if (q_valid) begin
               q_rd    = 1'b1;
               state_d = func_ok ? B1 : RESP;
            end
         end
         B1: begin
            if (beat_fail)    state_d = RESP;
            else if (beat_ok) state_d = split ? B2 : RESP;
         end
         B2: begin
            if (beat_fail | beat_ok) state_d = RESP;
         end
         RESP: begin
            if (resp_rdy) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= IDLE;
         func_q  <= '0;
         sz_q    <= '0;
         adr_q   <= '0;
         tid_q   <= '0;
         sel32_q <= '0;
         sdat_q  <= '0;
         lo_q    <= '0;
         hi_q    <= '0;
         cyc_q   <= 1'b0;
         stb_q   <= 1'b0;
         err_q   <= 1'b0;
         tmo_q   <= '0;
      end else begin
         state_q <= state_d;
         case (state_q)
            IDLE: begin
               if (q_valid) begin
                  func_q  <= q_req.func;
                  sz_q    <= q_req.sz;
                  adr_q   <= q_req.adr[AWID-1:0];
                  tid_q   <= q_req.tid;
                  sel32_q <= {16'h0000, fnSel(q_req.sz)} << q_req.adr[3:0];
                  sdat_q  <= {128'h0, q_req.dat} << {q_req.adr[3:0], 3'b000};
                  lo_q    <= '0;
                  hi_q    <= '0;
                  err_q   <= ~func_ok;
                  cyc_q   <= func_ok;
                  stb_q   <= func_ok;
                  tmo_q   <= '0;
               end
            end
            B1, B2: begin
               if (!stb_q) begin
                  stb_q <= 1'b1;
                  tmo_q <= '0;
               end else if (beat_fail) begin
                  err_q <= 1'b1;
                  stb_q <= 1'b0;
               end else if (beat_ok) begin
                  stb_q <= 1'b0;
                  tmo_q <= '0;
                  if (state_q == B1) lo_q <= dat_i;
                  else               hi_q <= dat_i;
               end else begin
                  tmo_q <= tmo_q + TW'(1);
               end
            end
            RESP: begin
               // The bus stays locked until the response is consumed
               if (resp_rdy) cyc_q <= 1'b0;
            end
            default: ;
         endcase
      end
   end

   bw_load_align u_align (
      .hi     (hi_q),
      .lo     (lo_q),
      .adr_lo (adr_q[3:0]),
      .sz     (sz_q),
      .func   (func_q),
      .res    (ext)
   );

   always_comb begin
      cyc_o    = cyc_q;
      stb_o    = stb_q;
      we_o     = 1'b0;
      sel_o    = '0;
      adr_o    = '0;
      dat_o    = '0;
      resp_v   = 1'b0;
      resp_tid = '0;
      resp_err = 1'b0;
      resp_dat = '0;
      busy     = (state_q != IDLE);
      case (state_q)
         B1: begin
            we_o  = (func_q == MR_STORE);
            adr_o = {adr_q[AWID-1:4], 4'h0};
            sel_o = sel32_q[15:0];
            dat_o = sdat_q[127:0];
         end
         B2: begin
            we_o  = (func_q == MR_STORE);
            adr_o = {adr_q[AWID-1:4] + (AWID-4)'(1), 4'h0};
            sel_o = sel32_q[31:16];
            dat_o = sdat_q[255:128];
         end
         RESP: begin
            resp_v   = 1'b1;
            resp_tid = tid_q;
            resp_err = err_q;
            resp_dat = err_q ? 128'h0 : ext;
         end
         default: ;
      endcase
   end

endmodule
